// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC gain-apply datapath.
package agc_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned MANT_W   = 8;
  localparam int unsigned EXP_W    = 4;
  localparam int unsigned FRAC_W   = 8;

  // sample * (256 + mantissa) needs SAMPLE_W + MANT_W + 1 bits.
  localparam int unsigned PROD_W = SAMPLE_W + MANT_W + 1;
  // One extra bit so adding the rounding bias cannot overflow.
  localparam int unsigned RND_W  = PROD_W + 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic [MANT_W-1:0] mantissa;
    logic [EXP_W-1:0]  exp;
  } gain_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // Unsigned linear gain factor 256 + mantissa (implicit leading one).
  function automatic logic [MANT_W:0] gain_factor(input logic [MANT_W-1:0] m);
    return {1'b1, m};
  endfunction

endpackage

// File: rtl/agc_round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to one sample.
// Two register stages (rounded value, then saturated output), both gated by en_i.
module agc_round_sat
  import agc_pkg::*;
#(
  parameter int unsigned ShW = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic signed [RND_W-1:0] prod_i,
  input  logic [ShW-1:0]          sh_i,
  output logic signed [SAMPLE_W-1:0] out_o,
  output logic                    clip_o
);

  logic signed [RND_W-1:0] bias, sum, rnd_d, rnd_q;
  logic signed [SAMPLE_W-1:0] sat_d;
  logic clip_d;

  // Add half an LSB of the result, then floor-shift: ties round toward +inf.
  always_comb begin
    bias  = RND_W'(1) <<< (sh_i - ShW'(1));
    sum   = prod_i + bias;
    rnd_d = sum >>> sh_i;
  end

  // Clip when the bits above the sample's sign bit are not a pure sign extension.
  always_comb begin
    clip_d = (|rnd_q[RND_W-1:SAMPLE_W-1]) & ~(&rnd_q[RND_W-1:SAMPLE_W-1]);
    sat_d  = rnd_q[SAMPLE_W-1:0];
    if (clip_d) begin
      sat_d = rnd_q[RND_W-1] ? SAMPLE_MIN : SAMPLE_MAX;
    end
  end

  // Rounded-value register and saturated output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rnd_q  <= '0;
      out_o  <= '0;
      clip_o <= 1'b0;
    end else if (en_i) begin
      rnd_q  <= rnd_d;
      out_o  <= sat_d;
      clip_o <= clip_d;
    end
  end

endmodule

// File: rtl/agc_gain_apply.sv
// Applies the AGC mantissa/exponent gain to a 12-bit I/Q stream: multiply, round,
// saturate over three stall-able pipeline stages with valid/ready on both sides.
// Optional saturation event counter enabled by AGC_GAIN_APPLY_SAT_CNT_EN.
module agc_gain_apply
  import agc_pkg::*;
#(
  parameter int unsigned EXP_BIAS = 10
`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
  , parameter int unsigned SAT_CNT_W = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [SAMPLE_W-1:0] sample_q,
  input  logic                       gain_valid,
  input  logic [MANT_W-1:0]          mantissa,
  input  logic [EXP_W-1:0]           exp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_i,
  output logic signed [SAMPLE_W-1:0] out_q,
`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
  input  logic                       sat_clr,
  output logic [SAT_CNT_W-1:0]       sat_count,
`endif
  output logic                       out_sat
);

  localparam int unsigned ShW = $clog2(FRAC_W + EXP_BIAS + 1);
  localparam gain_t GainUnity = '{mantissa: '0, exp: EXP_W'(EXP_BIAS)};

  logic adv, accept;
  gain_t gain_in, eff_gain;
  gain_t act_q, act_d, pend_q, pend_d;
  logic  pend_vld_q, pend_vld_d;

  logic signed [PROD_W-1:0] gain_ext, pi_d, pq_d, s1_pi_q, s1_pq_q;
  logic [ShW-1:0] sh_d, s1_sh_q;
  logic s1_vld_q, s2_vld_q, out_vld_q;
  logic clip_i, clip_q;

  assign adv       = !out_vld_q || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign out_valid = out_vld_q;
  assign out_sat   = clip_i || clip_q;

  // Gain selection: a coincident strobe beats pending, pending beats active.
  always_comb begin
    gain_in    = {mantissa, exp};
    eff_gain   = gain_valid ? gain_in : (pend_vld_q ? pend_q : act_q);
    act_d      = accept ? eff_gain : act_q;
    pend_d     = gain_valid ? gain_in : pend_q;
    pend_vld_d = accept ? 1'b0 : (gain_valid | pend_vld_q);
  end

  // S1 datapath: both components share the same gain and shift.
  always_comb begin
    gain_ext = $signed(PROD_W'(gain_factor(eff_gain.mantissa)));
    pi_d     = PROD_W'(sample_i) * gain_ext;
    pq_d     = PROD_W'(sample_q) * gain_ext;
    sh_d     = ShW'(FRAC_W + EXP_BIAS) - ShW'(eff_gain.exp);
  end

  // Gain registers update every cycle; pipeline stages only move on adv.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q      <= GainUnity;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_pi_q    <= '0;
      s1_pq_q    <= '0;
      s1_sh_q    <= '0;
      s2_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      if (adv) begin
        s1_vld_q  <= accept;
        s1_pi_q   <= pi_d;
        s1_pq_q   <= pq_d;
        s1_sh_q   <= sh_d;
        s2_vld_q  <= s1_vld_q;
        out_vld_q <= s2_vld_q;
      end
    end
  end

  agc_round_sat #(
    .ShW (ShW)
  ) u_rs_i (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (adv),
    .prod_i (RND_W'(s1_pi_q)),
    .sh_i   (s1_sh_q),
    .out_o  (out_i),
    .clip_o (clip_i)
  );

  agc_round_sat #(
    .ShW (ShW)
  ) u_rs_q (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (adv),
    .prod_i (RND_W'(s1_pq_q)),
    .sh_i   (s1_sh_q),
    .out_o  (out_q),
    .clip_o (clip_q)
  );

`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
  logic [SAT_CNT_W-1:0] cnt_q, cnt_d;

  // Count clipped handshakes, sticking at all-ones; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (out_vld_q && out_ready && out_sat && !(&cnt_q)) begin
      cnt_d = cnt_q + SAT_CNT_W'(1);
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_count = cnt_q;
`endif

endmodule

// File: tb/tb_agc_gain_apply.sv
// Directed self-checking bench for agc_gain_apply. Inputs change 1 time unit after
// the rising edge; outputs are observed on the falling edge.
module tb_agc_gain_apply;
  import agc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, gain_valid, out_valid, out_ready, out_sat;
  logic signed [SAMPLE_W-1:0] sample_i, sample_q, out_i, out_q;
  logic [MANT_W-1:0] mantissa;
  logic [EXP_W-1:0]  exp;
`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
  logic        sat_clr;
  logic [15:0] sat_count;
`endif

  always #5 clk = ~clk;

  agc_gain_apply #(
    .EXP_BIAS (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sample_i   (sample_i),
    .sample_q   (sample_q),
    .gain_valid (gain_valid),
    .mantissa   (mantissa),
    .exp        (exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_i      (out_i),
    .out_q      (out_q),
`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
    .sat_clr    (sat_clr),
    .sat_count  (sat_count),
`endif
    .out_sat    (out_sat)
  );

  typedef struct {
    int i;
    int q;
    int sat;
  } exp_t;

  typedef struct {
    int si; int sq; bit gv; int m; int e; int xi; int xq; int xs;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  bit   stall_prev = 1'b0;
  int   hold_i, hold_q, hold_s;

  task automatic check_eq(input string tag, input int act, input int want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair until accepted; expected result is queued on acceptance.
  task automatic send(input int si, input int sq, input bit gv, input int m, input int e,
                      input int xi, input int xq, input int xs);
    int  n;
    bit  acc;
    exp_t x;
    sample_i   = SAMPLE_W'(si);
    sample_q   = SAMPLE_W'(sq);
    mantissa   = MANT_W'(m);
    exp        = EXP_W'(e);
    gain_valid = gv;
    in_valid   = 1'b1;
    n          = 0;
    acc        = 1'b0;
    while (!acc) begin
      #1;
      acc = in_ready;
      if (acc) begin
        x = '{xi, xq, xs};
        sb.push_back(x);
      end
      @(posedge clk);
      #1;
      gain_valid = 1'b0;
      n++;
      if (!acc && n > 200) begin
        check_eq("accept_timeout", in_ready, 1);
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid   = 1'b0;
    gain_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain_left", sb.size(), 0);
  endtask

  // Output monitor: scoreboard compare on handshake, hold checks while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst || !mon_en) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_hold_i", out_i, hold_i);
        check_eq("stall_hold_q", out_q, hold_q);
        check_eq("stall_hold_sat", out_sat, hold_s);
      end
      if (out_valid && !out_ready) begin
        check_eq("stall_in_ready", in_ready, 0);
        stall_prev = 1'b1;
        hold_i = out_i;
        hold_q = out_q;
        hold_s = out_sat;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check_eq("out_i", out_i, e.i);
          check_eq("out_q", out_q, e.q);
          check_eq("out_sat", out_sat, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // Hand-computed vectors; gain carried forward when gv=0.
  vec_t vecs[10] = '{
    '{1000, 5, 1, 0, 11, 2000, 10, 0},         // x2
    '{1000, -2048, 1, 0, 12, 2047, -2048, 1},  // x4, both clip
    '{-2048, 0, 0, 0, 0, -2048, 0, 1},         // x4 carried forward
    '{3, -3, 1, 128, 10, 5, -4, 0},            // x1.5: 4.5->5, -4.5->-4
    '{1, -1, 0, 0, 0, 2, -1, 0},               // 1.5->2, -1.5->-1
    '{0, 2047, 0, 0, 0, 0, 2047, 1},           // 3070.5 clips
    '{1, -1, 1, 255, 15, 64, -64, 0},          // minimum shift 3
    '{2047, -2048, 1, 0, 0, 2, -2, 0},         // maximum shift 18
    '{-1, 1, 0, 0, 0, 0, 0, 0},
    '{-7, 2047, 1, 0, 10, -7, 2047, 0}         // back to unity
  };

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    gain_valid = 1'b0;
    sample_i   = '0;
    sample_q   = '0;
    mantissa   = '0;
    exp        = '0;
    out_ready  = 1'b1;
`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
    sat_clr    = 1'b0;
`endif

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_i", out_i, 0);
    check_eq("rst_out_q", out_q, 0);
    check_eq("rst_out_sat", out_sat, 0);
    check_eq("rst_in_ready", in_ready, 1);
`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
    check_eq("rst_sat_count", sat_count, 0);
`endif
    tick();
    rst    = 1'b1;
    mon_en = 1'b1;
    tick();

    // Unity default gain and 3-cycle latency.
    send(1000, -1000, 1'b0, 0, 0, 1000, -1000, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_c1", out_valid, 0);
    @(negedge clk);
    check_eq("lat_c2", out_valid, 0);
    @(negedge clk);
    check_eq("lat_c3", out_valid, 1);
    tick();
    drain();

    // Gain, rounding and saturation vectors, back to back.
    foreach (vecs[k]) begin
      send(vecs[k].si, vecs[k].sq, vecs[k].gv, vecs[k].m, vecs[k].e,
           vecs[k].xi, vecs[k].xq, vecs[k].xs);
    end
    idle(1);
    drain();

    // Gain strobe coincident with acceptance; earlier samples keep old gain.
    send(100, -100, 1'b0, 0, 0, 100, -100, 0);
    send(200, -200, 1'b0, 0, 0, 200, -200, 0);
    send(300, -300, 1'b1, 0, 11, 600, -600, 0);
    send(400, 7, 1'b0, 0, 0, 800, 14, 0);
    idle(1);
    drain();

    // Last strobe wins when several arrive before a sample.
    gain_valid = 1'b1;
    mantissa   = 8'd0;
    exp        = 4'd12;
    tick();
    exp        = 4'd10;
    tick();
    gain_valid = 1'b0;
    tick();
    send(500, -500, 1'b0, 0, 0, 500, -500, 0);
    idle(1);
    drain();

    // Backpressure: out_ready low for 5 cycles during a continuous stream.
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          send(k * 37 - 200, 150 - k * 11, 1'b0, 0, 0, k * 37 - 200, 150 - k * 11, 0);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
    // Saturation counter.
    send(1000, 0, 1'b1, 0, 12, 2047, 0, 1);
    send(0, -1000, 1'b0, 0, 0, 0, -2048, 1);
    send(100, 0, 1'b0, 0, 0, 400, 0, 0);
    send(600, 0, 1'b0, 0, 0, 2047, 0, 1);
    idle(1);
    drain();
    check_eq("sat_count_3", sat_count, 3);
    send(1000, 0, 1'b0, 0, 0, 2047, 0, 1);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) tick();
    check_eq("clr_wait_valid", out_valid, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check_eq("sat_count_clr", sat_count, 0);
    send(-1000, 0, 1'b0, 0, 0, -2048, 0, 1);
    send(5, 5, 1'b1, 0, 10, 5, 5, 0);
    idle(1);
    drain();
    check_eq("sat_count_1", sat_count, 1);
`endif

    // Reset mid-stream drops in-flight samples and the pending gain.
    send(11, 12, 1'b0, 0, 0, 11, 12, 0);
    send(21, 22, 1'b0, 0, 0, 21, 22, 0);
    send(31, 32, 1'b0, 0, 0, 31, 32, 0);
    in_valid   = 1'b0;
    gain_valid = 1'b1;
    mantissa   = 8'd0;
    exp        = 4'd12;
    tick();
    gain_valid = 1'b0;
    mon_en     = 1'b0;
    rst        = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_i", out_i, 0);
    check_eq("mid_rst_out_sat", out_sat, 0);
`ifdef AGC_GAIN_APPLY_SAT_CNT_EN
    check_eq("mid_rst_sat_count", sat_count, 0);
`endif
    tick();
    rst    = 1'b1;
    mon_en = 1'b1;
    tick();
    send(1000, -1000, 1'b0, 0, 0, 1000, -1000, 0);
    idle(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
